axibram_read: RTL and testbench

- AXI3 read-channel slave for PS Master GP0 (12-bit IDs, 4-bit len, 32-bit data). Serves bursts from block RAM or other synchronous-read devices.
- Sits beside the BRAM write slave on the same GP0 port and address map, and uses the same early-address/dev_ready arbitration scheme.
- Buffers AR requests and read data in fifo_same_clock instances.
- Generates word addresses and a BRAM read strobe, then returns data with rid/rlast/rresp.

---
 rtl/axibram_read_pkg.sv | 12 +
 rtl/axibram_read_if.sv | 29 ++
 rtl/axi_burst_addr_gen.sv | 27 ++
 rtl/fifo_same_clock.sv | 44 ++++
 rtl/axibram_read.sv | 165 ++++++++++++++++
 tb/tb_axibram_read.sv | 297 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/axibram_read_pkg.sv
// Shared constants and types for the GP0 BRAM read slave and its helper blocks.
package axibram_read_pkg;
  localparam int ID_W  = 12;
  localparam int LEN_W = 4;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RRESP_OKAY  = 2'b00;

  typedef enum logic {IDLE, BURST} rd_state_t;
endpackage

// File: rtl/axibram_read_if.sv
// AXI3 read-address and read-data channels of the PS GP0 port.
interface axibram_read_if;
  import axibram_read_pkg::*;

  logic [31:0]      araddr;
  logic             arvalid;
  logic             arready;
  logic [ID_W-1:0]  arid;
  logic [LEN_W-1:0] arlen;
  logic [1:0]       arsize;
  logic [1:0]       arburst;

  logic [31:0]      rdata;
  logic             rvalid;
  logic             rready;
  logic [ID_W-1:0]  rid;
  logic             rlast;
  logic [1:0]       rresp;

  modport master (
    output araddr, arvalid, arid, arlen, arsize, arburst, rready,
    input  arready, rdata, rvalid, rid, rlast, rresp
  );

  modport slave (
    input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
    output arready, rdata, rvalid, rid, rlast, rresp
  );
endinterface

// File: rtl/axi_burst_addr_gen.sv
// Next word address of an AXI burst; shared by the BRAM read and write slaves.
module axi_burst_addr_gen
  import axibram_read_pkg::*;
#(
  parameter int ADDRESS_BITS = 10
) (
  input  logic [ADDRESS_BITS-1:0] addr,
  input  logic [1:0]              burst,
  input  logic [LEN_W-1:0]        len,
  output logic [ADDRESS_BITS-1:0] next_addr
);
  logic [ADDRESS_BITS-1:0] inc;
  logic [ADDRESS_BITS-1:0] mask;

  assign inc  = addr + ADDRESS_BITS'(1);
  assign mask = ADDRESS_BITS'(len);

  // WRAP keeps the bits above the burst size and lets only the low bits roll over
  always_comb begin
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_INCR:  next_addr = inc;
      BURST_WRAP:  next_addr = (addr & ~mask) | (inc & mask);
      default:     next_addr = '0;
    endcase
  end
endmodule

// File: rtl/fifo_same_clock.sv
// Single-clock FIFO with 2**DATA_DEPTH entries, first-word-fall-through read port.
module fifo_same_clock #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic                  re,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  nempty,
  output logic                  half_full
);
  localparam int ENTRIES = 1 << DATA_DEPTH;

  logic [DATA_WIDTH-1:0] mem [ENTRIES];
  logic [DATA_DEPTH-1:0] wptr, rptr;
  logic [DATA_DEPTH:0]   count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (we) wptr <= wptr + DATA_DEPTH'(1);
      if (re) rptr <= rptr + DATA_DEPTH'(1);
      case ({we, re})
        2'b10:   count <= count + (DATA_DEPTH + 1)'(1);
        2'b01:   count <= count - (DATA_DEPTH + 1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= data_in;
  end

  assign data_out  = mem[rptr];
  assign nempty    = |count;
  assign half_full = count[DATA_DEPTH] | count[DATA_DEPTH-1];
endmodule

// File: rtl/axibram_read.sv
// AXI3 read slave serving bursts from BRAM-like synchronous-read devices on GP0.
// Define AXIBRAM_READ_REGOUT_EN to use the memory output register (read latency 2).
module axibram_read
  import axibram_read_pkg::*;
#(
  parameter int ADDRESS_BITS = 10
) (
  input  logic                    aclk,
  input  logic                    rst,
  axibram_read_if.slave           axi,
  output logic [ADDRESS_BITS-1:0] pre_araddr,
  output logic                    start_burst,
  input  logic                    dev_ready,
  output logic                    bram_rclk,
  output logic [ADDRESS_BITS-1:0] bram_raddr,
  output logic                    bram_ren,
  output logic                    bram_regen,
  input  logic [31:0]             bram_rdata
);
  localparam int AR_W = 20 + ADDRESS_BITS;
  localparam int R_W  = ID_W + 1 + 32;

  logic [AR_W-1:0]         ar_head;
  logic                    ar_nempty, ar_half_full;
  logic [ID_W-1:0]         head_id;
  logic [1:0]              head_burst, head_size;
  logic [LEN_W-1:0]        head_len;

  rd_state_t               state, state_nxt;
  logic                    dev_ready_r;
  logic [4:0]              pending;
  logic [ADDRESS_BITS-1:0] addr, addr_nxt;
  logic [1:0]              burst;
  logic [LEN_W-1:0]        len, remaining;
  logic [ID_W-1:0]         id;
  logic                    ren, last_beat;

  logic                    vld_p0;
  logic [ID_W:0]           tag_p0;
  logic                    r_we, r_pop, r_nempty, r_half_full;
  logic [ID_W:0]           r_tag;
  logic [R_W-1:0]          r_head;
  logic                    unused_bits;

  fifo_same_clock #(.DATA_WIDTH(AR_W), .DATA_DEPTH(4)) i_ar_fifo (
    .clk       (aclk),
    .rst       (rst),
    .we        (axi.arvalid && axi.arready),
    .re        (start_burst),
    .data_in   ({axi.arid, axi.arburst, axi.arsize, axi.arlen, axi.araddr[ADDRESS_BITS+1:2]}),
    .data_out  (ar_head),
    .nempty    (ar_nempty),
    .half_full (ar_half_full)
  );

  assign axi.arready = ~ar_half_full;
  assign {head_id, head_burst, head_size, head_len, pre_araddr} = ar_head;

  axi_burst_addr_gen #(.ADDRESS_BITS(ADDRESS_BITS)) i_addr_gen (
    .addr      (addr),
    .burst     (burst),
    .len       (len),
    .next_addr (addr_nxt)
  );

  // A beat is issued only while the R FIFO still has a free slot reserved for it
  always_comb begin
    state_nxt   = state;
    ren         = 1'b0;
    last_beat   = 1'b0;
    start_burst = 1'b0;
    if (state == BURST) begin
      ren       = dev_ready_r && !pending[4];
      last_beat = ren && (remaining == '0);
    end
    start_burst = ar_nempty && dev_ready_r && ((state == IDLE) || last_beat);
    if (start_burst)    state_nxt = BURST;
    else if (last_beat) state_nxt = IDLE;
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      dev_ready_r <= 1'b0;
      pending     <= '0;
    end else begin
      state       <= state_nxt;
      dev_ready_r <= dev_ready;
      case ({ren, r_pop})
        2'b10:   pending <= pending + 5'd1;
        2'b01:   pending <= pending - 5'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge aclk) begin
    if (start_burst) begin
      addr      <= pre_araddr;
      burst     <= head_burst;
      len       <= head_len;
      remaining <= head_len;
      id        <= head_id;
    end else if (ren) begin
      addr      <= addr_nxt;
      remaining <= remaining - LEN_W'(1);
    end
  end

  // ---- stage p0: memory read issued, tag waits for its data ----
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) vld_p0 <= 1'b0;
    else     vld_p0 <= ren;
  end

  always_ff @(posedge aclk) begin
    if (ren) tag_p0 <= {id, (remaining == '0)};
  end

`ifdef AXIBRAM_READ_REGOUT_EN
  logic          vld_p1;
  logic [ID_W:0] tag_p1;

  // ---- stage p1: memory output register loads ----
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= vld_p0;
  end

  always_ff @(posedge aclk) begin
    if (vld_p0) tag_p1 <= tag_p0;
  end

  assign r_we       = vld_p1;
  assign r_tag      = tag_p1;
  assign bram_regen = vld_p0;
`else
  assign r_we       = vld_p0;
  assign r_tag      = tag_p0;
  assign bram_regen = 1'b1;
`endif

  fifo_same_clock #(.DATA_WIDTH(R_W), .DATA_DEPTH(4)) i_r_fifo (
    .clk       (aclk),
    .rst       (rst),
    .we        (r_we),
    .re        (r_pop),
    .data_in   ({r_tag, bram_rdata}),
    .data_out  (r_head),
    .nempty    (r_nempty),
    .half_full (r_half_full)
  );

  assign r_pop      = r_nempty && axi.rready;
  assign axi.rvalid = r_nempty;
  // Idle outputs read as zero instead of stale FIFO contents
  assign {axi.rid, axi.rlast, axi.rdata} = r_nempty ? r_head : '0;
  assign axi.rresp  = RRESP_OKAY;

  assign bram_rclk  = aclk;
  assign bram_raddr = addr;
  assign bram_ren   = ren;

  assign unused_bits = ^{head_size, r_half_full, axi.araddr[31:ADDRESS_BITS+2], axi.araddr[1:0]};
endmodule

// File: tb/tb_axibram_read.sv
// Scoreboard bench for axibram_read: reference burst model, BRAM model and beat monitor.
`timescale 1ns/1ps
module tb_axibram_read;
  import axibram_read_pkg::*;

  localparam int AB = 10;
`ifdef AXIBRAM_READ_REGOUT_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic [11:0] id;
    logic        last;
  } beat_t;

  logic          aclk = 1'b0;
  logic          rst  = 1'b1;
  logic          dev_ready;
  logic [AB-1:0] unused_pre_araddr;
  logic          start_burst;
  logic          unused_rclk;
  logic [AB-1:0] bram_raddr;
  logic          bram_ren, bram_regen;
  logic [31:0]   bram_rdata;

  axibram_read_if axi();

  axibram_read #(.ADDRESS_BITS(AB)) dut (
    .aclk        (aclk),
    .rst         (rst),
    .axi         (axi),
    .pre_araddr  (unused_pre_araddr),
    .start_burst (start_burst),
    .dev_ready   (dev_ready),
    .bram_rclk   (unused_rclk),
    .bram_raddr  (bram_raddr),
    .bram_ren    (bram_ren),
    .bram_regen  (bram_regen),
    .bram_rdata  (bram_rdata)
  );

  always #5 aclk = ~aclk;

  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    acc_cycle = 0;
  int    beats_seen = 0;
  int    ren_blocked = 0;
  int    ren_cycles[$];
  beat_t exp_q[$];
  int    exp_addr_q[$];
  logic  rnd_mode = 1'b0;
  logic  dr_prev = 1'b0;

  logic [31:0] mem [1024];
  logic [31:0] mem_q;

  always @(posedge aclk) cyc <= cyc + 1;
  always @(posedge aclk) dr_prev <= dev_ready;
  always @(posedge aclk) if (bram_ren) mem_q <= mem[bram_raddr];

`ifdef AXIBRAM_READ_REGOUT_EN
  logic [31:0] mem_q2;
  always @(posedge aclk) if (bram_regen) mem_q2 <= mem_q;
  assign bram_rdata = mem_q2;
`else
  assign bram_rdata = mem_q;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word address of beat i, from the burst's wrap boundary rather than bit masks
  function automatic int ref_addr(int start, int len, int burst, int i);
    int size, base;
    case (burst)
      0: return start;
      1: return (start + i) % 1024;
      2: begin
        size = len + 1;
        base = start - (start % size);
        return base + ((start - base + i) % size);
      end
      default: return (i == 0) ? start : 0;
    endcase
  endfunction

  beat_t mon_e;
  int    mon_a;
  always @(negedge aclk) begin
    if (!rst) begin
      if (bram_ren) begin
        ren_cycles.push_back(cyc);
        if (!dr_prev) ren_blocked++;
        if (exp_addr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected ren: raddr 0x%0h, no read expected (cycle %0d)", bram_raddr, cyc);
        end else begin
          mon_a = exp_addr_q.pop_front();
          check("bram_raddr", 64'(bram_raddr), 64'(mon_a));
        end
      end
      if (axi.rvalid && axi.rready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL stray beat: rdata 0x%0h rid 0x%0h, none expected (cycle %0d)", axi.rdata, axi.rid, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("rbeat {rdata,rid,rlast}", 64'({axi.rdata, axi.rid, axi.rlast}), 64'(mon_e));
          check("rresp", 64'(axi.rresp), 64'(RRESP_OKAY));
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
    if (rnd_mode) begin
      axi.rready = ($urandom_range(0, 3) != 0);
      dev_ready  = ($urandom_range(0, 5) != 0);
    end
  endtask

  task automatic send_ar(input int waddr, input int len, input int burst, input int id);
    int          n;
    int          a;
    beat_t       b;
    logic [31:0] hi;
    n  = 0;
    hi = $urandom();
    axi.araddr  = {hi[31:AB+2], AB'(waddr), hi[1:0]};
    axi.arid    = 12'(id);
    axi.arlen   = 4'(len);
    axi.arburst = 2'(burst);
    axi.arsize  = 2'b10;
    axi.arvalid = 1'b1;
    while (!axi.arready && n < 500) begin
      tick();
      n++;
    end
    check("arready within bound", 64'(axi.arready), 64'(1));
    if (!axi.arready) begin
      axi.arvalid = 1'b0;
      return;
    end
    for (int i = 0; i <= len; i++) begin
      a = ref_addr(waddr, len, burst, i);
      exp_addr_q.push_back(a);
      b.data = mem[a];
      b.id   = 12'(id);
      b.last = (i == len);
      exp_q.push_back(b);
    end
    acc_cycle = cyc;
    tick();
    axi.arvalid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp_addr_q.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    check("scoreboard drained", 64'(exp_q.size() + exp_addr_q.size()), 64'(0));
    repeat (10) tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, " arready"},     64'(axi.arready), 64'(1));
    check({tag, " rvalid"},      64'(axi.rvalid),  64'(0));
    check({tag, " rlast"},       64'(axi.rlast),   64'(0));
    check({tag, " rid"},         64'(axi.rid),     64'(0));
    check({tag, " rresp"},       64'(axi.rresp),   64'(0));
    check({tag, " bram_ren"},    64'(bram_ren),    64'(0));
    check({tag, " start_burst"}, 64'(start_burst), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, n, i1, b0, bt, ln;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom();
    for (int i = 0; i < 4; i++) mem[16 + i] = 32'(i + 1) * 32'h1111_1111;
    axi.araddr = '0; axi.arvalid = 1'b0; axi.arid = '0; axi.arlen = '0;
    axi.arsize = 2'b10; axi.arburst = 2'b01; axi.rready = 1'b1; dev_ready = 1'b1;

    rst = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check_reset("por");
    rst = 1'b0;
    tick(); tick();

    // INCR burst, latency and data pattern
    idx = ren_cycles.size();
    send_ar(16, 3, 1, 'h5A5);
    check("start_burst at N+1", 64'(start_burst), 64'(1));
    n = 0;
    while (!axi.rvalid && n < 20) begin tick(); n++; end
    check("first rvalid latency", 64'(cyc - acc_cycle), 64'(LAT));
    drain();
    check("incr ren count", 64'(ren_cycles.size() - idx), 64'(4));
    if (ren_cycles.size() > idx)
      check("first ren at N+2", 64'(ren_cycles[idx] - acc_cycle), 64'(2));

    // WRAP 14,15,12,13 and FIXED 7,7,7
    send_ar(14, 3, 2, 'h123);
    send_ar(7, 2, 0, 'h456);
    drain();

    // back-to-back bursts issue without a gap
    idx = ren_cycles.size();
    send_ar(100, 0, 1, 'h001);
    send_ar(200, 15, 1, 'h002);
    drain();
    check("b2b ren count", 64'(ren_cycles.size() - idx), 64'(17));
    if (ren_cycles.size() >= idx + 17)
      check("b2b ren span", 64'(ren_cycles[idx + 16] - ren_cycles[idx]), 64'(16));

    // backpressure caps outstanding beats at 16
    axi.rready = 1'b0;
    idx = ren_cycles.size();
    send_ar(300, 15, 1, 'h0A1);
    send_ar(320, 15, 1, 'h0A2);
    repeat (40) tick();
    check("ren stops at 16 pending", 64'(ren_cycles.size() - idx), 64'(16));
    axi.rready = 1'b1;
    drain();
    check("backpressure total rens", 64'(ren_cycles.size() - idx), 64'(32));

    // dev_ready stall mid-burst
    idx = ren_cycles.size();
    b0  = ren_blocked;
    send_ar(500, 15, 1, 'h0B0);
    n = 0;
    while (ren_cycles.size() - idx < 4 && n < 50) begin tick(); n++; end
    dev_ready = 1'b0;
    tick();
    i1 = ren_cycles.size();
    repeat (4) tick();
    check("no ren while stalled", 64'(ren_cycles.size() - i1), 64'(0));
    dev_ready = 1'b1;
    drain();
    check("ren only with dev_ready_r", 64'(ren_blocked - b0), 64'(0));
    check("stalled burst rens", 64'(ren_cycles.size() - idx), 64'(16));

    // reset at the third beat
    b0 = beats_seen;
    send_ar(600, 7, 1, 'h0C0);
    n = 0;
    while (beats_seen - b0 < 3 && n < 50) begin tick(); n++; end
    rst = 1'b1;
    exp_q.delete();
    exp_addr_q.delete();
    #1;
    check_reset("mid-burst");
    repeat (3) tick();
    rst = 1'b0;
    tick();
    send_ar(610, 3, 1, 'h0C1);
    drain();

    // randomized bursts with random rready/dev_ready
    rnd_mode = 1'b1;
    for (int k = 0; k < 40; k++) begin
      bt = $urandom_range(0, 3);
      ln = (bt == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
      send_ar($urandom_range(0, 1023), ln, bt, $urandom_range(0, 4095));
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    rnd_mode = 1'b0;
    axi.rready = 1'b1;
    dev_ready  = 1'b1;
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
